irq_pending_ctrl: RTL and testbench

Parametrised successor to the basic per-source pending latch. It adds input synchronisation, per-source level/edge and polarity selection, and an enable mask. It also adds a registered lowest-index-first request output, a claim/complete in-service handshake, and sticky overflow flags for lost edges. It sits between raw peripheral interrupt lines and the CPU-side interrupt interface.

---
 rtl/irq_pending_ctrl.sv | 112 +++++++++++
 tb/tb_irq_pending_ctrl.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_pending_ctrl.sv
// Interrupt pending controller: synchronised sources, edge/level and polarity
// per line, enable mask, lowest-index request and claim/complete handshake.
module irq_pending_ctrl #(
  parameter int NUM_IRQ     = 8,
  parameter int SYNC_STAGES = 2,
  parameter int ID_W        = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_sources,
  input  logic [NUM_IRQ-1:0] irq_edge,
  input  logic [NUM_IRQ-1:0] irq_pol,
  input  logic [NUM_IRQ-1:0] irq_enable,
  input  logic [NUM_IRQ-1:0] irq_clear,
  input  logic [NUM_IRQ-1:0] irq_set,
  input  logic               claim_req,
  input  logic               complete_req,
  input  logic [ID_W-1:0]    complete_id,
  output logic               irq_valid,
  output logic [ID_W-1:0]    irq_id,
  output logic [NUM_IRQ-1:0] irq_pending,
  output logic [NUM_IRQ-1:0] irq_active,
  output logic [NUM_IRQ-1:0] irq_overflow
);

  logic [NUM_IRQ-1:0] sync_q [SYNC_STAGES];
  logic [NUM_IRQ-1:0] s;
  logic [NUM_IRQ-1:0] prev;
  logic [NUM_IRQ-1:0] claim_hit;
  logic [NUM_IRQ-1:0] cmp_hit;
  logic [NUM_IRQ-1:0] evt;
  logic [NUM_IRQ-1:0] pend_n;
  logic [NUM_IRQ-1:0] act_n;
  logic [NUM_IRQ-1:0] ovf_n;
  logic [NUM_IRQ-1:0] elig;
  logic [ID_W-1:0]    id_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= '0;
      end
    end else begin
      sync_q[0] <= irq_sources;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
    end
  end

  assign s = sync_q[SYNC_STAGES-1] ~^ irq_pol;

  always_comb begin
    claim_hit = '0;
    cmp_hit   = '0;
    evt       = '0;
    pend_n    = irq_pending;
    act_n     = irq_active;
    ovf_n     = irq_overflow;
    for (int i = 0; i < NUM_IRQ; i++) begin
      claim_hit[i] = claim_req & irq_valid & (irq_id == ID_W'(i));
      cmp_hit[i]   = complete_req & (complete_id == ID_W'(i));
      // a level source being claimed is already in service this cycle
      evt[i] = irq_edge[i] ? (s[i] & ~prev[i])
                           : (s[i] & ~(irq_active[i] | claim_hit[i]));
      if (irq_clear[i]) begin
        pend_n[i] = 1'b0;
        ovf_n[i]  = 1'b0;
      end else begin
        if (evt[i] | irq_set[i]) begin
          pend_n[i] = 1'b1;
        end else if (claim_hit[i]) begin
          pend_n[i] = 1'b0;
        end
        if (irq_edge[i] & evt[i] & irq_pending[i] & ~claim_hit[i]) begin
          ovf_n[i] = 1'b1;
        end
      end
      act_n[i] = (irq_active[i] & ~cmp_hit[i]) | claim_hit[i];
    end
  end

  assign elig = irq_pending & irq_enable & ~irq_active & ~claim_hit;

  always_comb begin
    id_n = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (elig[i]) begin
        id_n = ID_W'(i);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev         <= '0;
      irq_pending  <= '0;
      irq_active   <= '0;
      irq_overflow <= '0;
      irq_valid    <= 1'b0;
      irq_id       <= '0;
    end else begin
      prev         <= s;
      irq_pending  <= pend_n;
      irq_active   <= act_n;
      irq_overflow <= ovf_n;
      irq_valid    <= |elig;
      irq_id       <= id_n;
    end
  end

endmodule

// File: tb/tb_irq_pending_ctrl.sv
// Directed bench for irq_pending_ctrl (NUM_IRQ=8, SYNC_STAGES=2).
// Inputs change 1ns after each rising edge; outputs are checked there too.
module tb_irq_pending_ctrl;

  logic       clk;
  logic       rst;
  logic [7:0] irq_sources;
  logic [7:0] irq_edge;
  logic [7:0] irq_pol;
  logic [7:0] irq_enable;
  logic [7:0] irq_clear;
  logic [7:0] irq_set;
  logic       claim_req;
  logic       complete_req;
  logic [2:0] complete_id;
  logic       irq_valid;
  logic [2:0] irq_id;
  logic [7:0] irq_pending;
  logic [7:0] irq_active;
  logic [7:0] irq_overflow;

  int pass_cnt;
  int total_cnt;

  irq_pending_ctrl #(
    .NUM_IRQ(8),
    .SYNC_STAGES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .irq_sources(irq_sources),
    .irq_edge(irq_edge),
    .irq_pol(irq_pol),
    .irq_enable(irq_enable),
    .irq_clear(irq_clear),
    .irq_set(irq_set),
    .claim_req(claim_req),
    .complete_req(complete_req),
    .complete_id(complete_id),
    .irq_valid(irq_valid),
    .irq_id(irq_id),
    .irq_pending(irq_pending),
    .irq_active(irq_active),
    .irq_overflow(irq_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    total_cnt++;
    if ({irq_valid, irq_id, irq_pending, irq_active, irq_overflow} !== 28'h0)
      $display("FAIL reset: valid=%b id=%0d pend=%h act=%h ovf=%h, need all 0",
               irq_valid, irq_id, irq_pending, irq_active, irq_overflow);
    else pass_cnt++;
  endtask

  task automatic test_edge;
    irq_sources[3] = 1'b1;
    tick(2);
    total_cnt++;
    if (irq_pending !== 8'h00)
      $display("FAIL edge_early: pend=%h need 00", irq_pending);
    else pass_cnt++;
    tick(1);
    irq_sources[3] = 1'b0;
    total_cnt++;
    if (irq_pending !== 8'h08 || irq_valid !== 1'b0)
      $display("FAIL edge_pend: pend=%h valid=%b need 08/0",
               irq_pending, irq_valid);
    else pass_cnt++;
    tick(1);
    total_cnt++;
    if (irq_valid !== 1'b1 || irq_id !== 3'd3)
      $display("FAIL edge_valid: valid=%b id=%0d need 1/3", irq_valid, irq_id);
    else pass_cnt++;
    claim_req = 1'b1;
    tick(1);
    claim_req = 1'b0;
    total_cnt++;
    if (irq_active !== 8'h08 || irq_pending !== 8'h00 || irq_valid !== 1'b0)
      $display("FAIL edge_claim: act=%h pend=%h valid=%b need 08/00/0",
               irq_active, irq_pending, irq_valid);
    else pass_cnt++;
    complete_req = 1'b1;
    complete_id  = 3'd3;
    tick(1);
    complete_req = 1'b0;
    total_cnt++;
    if (irq_active !== 8'h00)
      $display("FAIL edge_complete: act=%h need 00", irq_active);
    else pass_cnt++;
    tick(3);
  endtask

  task automatic test_priority;
    irq_set = 8'h24;
    tick(1);
    irq_set = 8'h00;
    total_cnt++;
    if (irq_pending !== 8'h24 || irq_valid !== 1'b0)
      $display("FAIL prio_set: pend=%h valid=%b need 24/0",
               irq_pending, irq_valid);
    else pass_cnt++;
    tick(1);
    total_cnt++;
    if (irq_valid !== 1'b1 || irq_id !== 3'd2)
      $display("FAIL prio_id: valid=%b id=%0d need 1/2", irq_valid, irq_id);
    else pass_cnt++;
    claim_req = 1'b1;
    tick(1);
    claim_req = 1'b0;
    total_cnt++;
    if (irq_valid !== 1'b1 || irq_id !== 3'd5 || irq_active !== 8'h04 ||
        irq_pending !== 8'h20)
      $display("FAIL prio_next: valid=%b id=%0d act=%h pend=%h need 1/5/04/20",
               irq_valid, irq_id, irq_active, irq_pending);
    else pass_cnt++;
    complete_req = 1'b1;
    complete_id  = 3'd7;
    tick(1);
    total_cnt++;
    if (irq_active !== 8'h04)
      $display("FAIL prio_cmp_inactive: act=%h need 04", irq_active);
    else pass_cnt++;
    complete_id = 3'd2;
    tick(1);
    complete_req = 1'b0;
    total_cnt++;
    if (irq_active !== 8'h00)
      $display("FAIL prio_cmp2: act=%h need 00", irq_active);
    else pass_cnt++;
    claim_req = 1'b1;
    tick(1);
    claim_req    = 1'b0;
    complete_req = 1'b1;
    complete_id  = 3'd5;
    tick(1);
    complete_req = 1'b0;
    total_cnt++;
    if (irq_active !== 8'h00 || irq_pending !== 8'h00 || irq_valid !== 1'b0)
      $display("FAIL prio_drain: act=%h pend=%h valid=%b need 00/00/0",
               irq_active, irq_pending, irq_valid);
    else pass_cnt++;
  endtask

  task automatic test_overflow;
    irq_sources[1] = 1'b1;
    tick(2);
    irq_sources[1] = 1'b0;
    tick(2);
    irq_sources[1] = 1'b1;
    tick(2);
    irq_sources[1] = 1'b0;
    tick(4);
    total_cnt++;
    if (irq_pending !== 8'h02 || irq_overflow !== 8'h02)
      $display("FAIL ovf_set: pend=%h ovf=%h need 02/02",
               irq_pending, irq_overflow);
    else pass_cnt++;
    irq_clear = 8'h02;
    tick(1);
    irq_clear = 8'h00;
    total_cnt++;
    if (irq_pending !== 8'h00 || irq_overflow !== 8'h00)
      $display("FAIL ovf_clear: pend=%h ovf=%h need 00/00",
               irq_pending, irq_overflow);
    else pass_cnt++;
    tick(1);
  endtask

  task automatic test_level;
    irq_sources[0] = 1'b1;
    irq_pol[0]     = 1'b0;
    irq_edge[0]    = 1'b0;
    tick(3);
    irq_clear = 8'h01;
    tick(1);
    irq_clear = 8'h00;
    tick(1);
    total_cnt++;
    if (irq_pending !== 8'h00 || irq_valid !== 1'b0)
      $display("FAIL lvl_idle: pend=%h valid=%b need 00/0",
               irq_pending, irq_valid);
    else pass_cnt++;
    irq_sources[0] = 1'b0;
    tick(4);
    total_cnt++;
    if (irq_pending !== 8'h01 || irq_valid !== 1'b1 || irq_id !== 3'd0)
      $display("FAIL lvl_req: pend=%h valid=%b id=%0d need 01/1/0",
               irq_pending, irq_valid, irq_id);
    else pass_cnt++;
    claim_req = 1'b1;
    tick(1);
    claim_req = 1'b0;
    tick(2);
    total_cnt++;
    if (irq_pending !== 8'h00 || irq_active !== 8'h01 || irq_valid !== 1'b0)
      $display("FAIL lvl_inservice: pend=%h act=%h valid=%b need 00/01/0",
               irq_pending, irq_active, irq_valid);
    else pass_cnt++;
    complete_req = 1'b1;
    complete_id  = 3'd0;
    tick(1);
    complete_req = 1'b0;
    total_cnt++;
    if (irq_pending !== 8'h00 || irq_active !== 8'h00)
      $display("FAIL lvl_complete: pend=%h act=%h need 00/00",
               irq_pending, irq_active);
    else pass_cnt++;
    tick(1);
    total_cnt++;
    if (irq_pending !== 8'h01)
      $display("FAIL lvl_repend: pend=%h need 01", irq_pending);
    else pass_cnt++;
    irq_sources[0] = 1'b1;
    tick(3);
    irq_clear = 8'h01;
    tick(1);
    irq_clear = 8'h00;
    tick(2);
  endtask

  task automatic test_simultaneous;
    irq_sources[4] = 1'b1;
    irq_set        = 8'h10;
    tick(1);
    irq_set = 8'h00;
    tick(1);
    total_cnt++;
    if (irq_valid !== 1'b1 || irq_id !== 3'd4)
      $display("FAIL sim_offer: valid=%b id=%0d need 1/4", irq_valid, irq_id);
    else pass_cnt++;
    claim_req = 1'b1;
    tick(1);
    claim_req = 1'b0;
    total_cnt++;
    if (irq_active !== 8'h10 || irq_pending !== 8'h10 ||
        irq_overflow !== 8'h00 || irq_valid !== 1'b0)
      $display("FAIL sim_claim_evt: act=%h pend=%h ovf=%h valid=%b need 10/10/00/0",
               irq_active, irq_pending, irq_overflow, irq_valid);
    else pass_cnt++;
    irq_sources[4] = 1'b0;
    tick(3);
    irq_sources[4] = 1'b1;
    tick(2);
    irq_clear = 8'h10;
    tick(1);
    irq_clear = 8'h00;
    total_cnt++;
    if (irq_pending !== 8'h00 || irq_overflow !== 8'h00)
      $display("FAIL sim_clear_evt: pend=%h ovf=%h need 00/00",
               irq_pending, irq_overflow);
    else pass_cnt++;
    irq_sources[4] = 1'b0;
    complete_req   = 1'b1;
    complete_id    = 3'd4;
    tick(1);
    complete_req = 1'b0;
    tick(3);
  endtask

  task automatic test_mask_reset;
    irq_enable = 8'hBF;
    irq_set    = 8'h40;
    tick(1);
    irq_set = 8'h00;
    tick(2);
    total_cnt++;
    if (irq_pending !== 8'h40 || irq_valid !== 1'b0)
      $display("FAIL mask_block: pend=%h valid=%b need 40/0",
               irq_pending, irq_valid);
    else pass_cnt++;
    irq_enable = 8'hFF;
    tick(1);
    total_cnt++;
    if (irq_valid !== 1'b1 || irq_id !== 3'd6)
      $display("FAIL mask_enable: valid=%b id=%0d need 1/6", irq_valid, irq_id);
    else pass_cnt++;
    claim_req = 1'b1;
    #3;
    rst = 1'b1;
    #1;
    total_cnt++;
    if ({irq_valid, irq_id, irq_pending, irq_active, irq_overflow} !== 28'h0)
      $display("FAIL async_reset: valid=%b id=%0d pend=%h act=%h ovf=%h, need all 0",
               irq_valid, irq_id, irq_pending, irq_active, irq_overflow);
    else pass_cnt++;
    claim_req = 1'b0;
    tick(2);
    total_cnt++;
    if (irq_active !== 8'h00 || irq_valid !== 1'b0)
      $display("FAIL reset_hold: act=%h valid=%b need 00/0",
               irq_active, irq_valid);
    else pass_cnt++;
  endtask

  initial begin
    pass_cnt     = 0;
    total_cnt    = 0;
    rst          = 1'b1;
    irq_sources  = 8'h00;
    irq_edge     = 8'hFF;
    irq_pol      = 8'hFF;
    irq_enable   = 8'hFF;
    irq_clear    = 8'h00;
    irq_set      = 8'h00;
    claim_req    = 1'b0;
    complete_req = 1'b0;
    complete_id  = 3'd0;
    tick(2);
    test_reset;
    rst = 1'b0;
    tick(1);
    test_edge;
    test_priority;
    test_overflow;
    test_level;
    test_simultaneous;
    test_mask_reset;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
